// File: rtl/memory_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_if
// Description : CPU bus / BRAM write-port bundle for memory_bus. The master
//               side drives the sampled CPU pins. The slave side (memory_bus)
//               returns one write strobe and one address per BRAM region,
//               plus a shared write-data bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_bus_if;
    logic        EN;
    logic        WE;
    logic [1:0]  BRAM_SELECT;
    logic [13:0] BRAM_ADDR;
    logic [15:0] DATA_IN;

    logic        CNT_WE;
    logic [13:0] CNT_ADDR;
    logic        MOD_WE;
    logic [15:0] MOD_ADDR;
    logic        PWE_WE;
    logic [7:0]  PWE_ADDR;
    logic        STM_WE;
    logic [18:0] STM_ADDR;
    logic [15:0] WDATA;

    modport master (
        output EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN,
        input  CNT_WE, CNT_ADDR, MOD_WE, MOD_ADDR, PWE_WE, PWE_ADDR,
               STM_WE, STM_ADDR, WDATA
    );

    modport slave (
        input  EN, WE, BRAM_SELECT, BRAM_ADDR, DATA_IN,
        output CNT_WE, CNT_ADDR, MOD_WE, MOD_ADDR, PWE_WE, PWE_ADDR,
               STM_WE, STM_ADDR, WDATA
    );
endinterface
`default_nettype wire

// File: rtl/memory_bus.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus
// Description : CPU bus front end. Registers the CPU pins and turns each
//               rising edge of (EN & WE) into a single-cycle write strobe for
//               one of four BRAM regions. Snoops controller MAIN writes to
//               keep the segment/page bits that widen the modulation and STM
//               BRAM addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus #(
    parameter logic [1:0] SEL_CONTROLLER   = 2'd0,
    parameter logic [1:0] SEL_MOD          = 2'd1,
    parameter logic [1:0] SEL_PWE_TABLE    = 2'd2,
    parameter logic [1:0] SEL_STM          = 2'd3,
    parameter logic [7:0] ADDR_MOD_WR_SEG  = 8'h20,
    parameter logic [7:0] ADDR_MOD_WR_PAGE = 8'h21,
    parameter logic [7:0] ADDR_STM_WR_SEG  = 8'h50,
    parameter logic [7:0] ADDR_STM_WR_PAGE = 8'h51
) (
    input  wire logic    BUS_CLK,
    input  wire logic    RST,
    memory_bus_if.slave  bus
);

    // Input sampling stage
    logic        r_en;
    logic        r_we;
    logic [1:0]  r_sel;
    logic [13:0] r_addr;
    logic [15:0] r_data;

    // Edge detection / second pipeline stage
    logic        r_valid;
    logic        r_wr_prev;
    logic        r_evt;
    logic [1:0]  r_sel2;
    logic [13:0] r_addr2;
    logic [15:0] r_data2;

    // Write-side segment/page state
    logic        r_mod_seg;
    logic        r_mod_page;
    logic        r_stm_seg;
    logic [3:0]  r_stm_page;

    // Output registers
    logic        r_cnt_we;
    logic        r_mod_we;
    logic        r_pwe_we;
    logic        r_stm_we;
    logic [13:0] r_cnt_addr;
    logic [15:0] r_mod_addr;
    logic [7:0]  r_pwe_addr;
    logic [18:0] r_stm_addr;
    logic [15:0] r_wdata;

    logic        w_wr;
    logic        w_evt;
    logic        w_main_wr;

    assign w_wr      = r_en & r_we;
    assign w_evt     = w_wr & ~r_wr_prev;
    // Controller write landing in the MAIN sub-block (address bits 13:8 zero)
    assign w_main_wr = r_evt && (r_sel2 == SEL_CONTROLLER) && (r_addr2[13:8] == 6'd0);

    // Register every CPU bus pin on each clock edge
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_en   <= 1'b0;
            r_we   <= 1'b0;
            r_sel  <= 2'd0;
            r_addr <= 14'd0;
            r_data <= 16'd0;
        end else begin
            r_en   <= bus.EN;
            r_we   <= bus.WE;
            r_sel  <= bus.BRAM_SELECT;
            r_addr <= bus.BRAM_ADDR;
            r_data <= bus.DATA_IN;
        end
    end

    // Rising-edge detect on wr. History resets to "busy" and only starts
    // tracking once the sampling stage holds real bus data, so a write that
    // is still held across reset release never produces a strobe.
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_valid   <= 1'b0;
            r_wr_prev <= 1'b1;
            r_evt     <= 1'b0;
            r_sel2    <= 2'd0;
            r_addr2   <= 14'd0;
            r_data2   <= 16'd0;
        end else begin
            r_valid <= 1'b1;
            if (r_valid) begin
                r_wr_prev <= w_wr;
            end
            r_evt   <= w_evt & r_valid;
            r_sel2  <= r_sel;
            r_addr2 <= r_addr;
            r_data2 <= r_data;
        end
    end

    // Snoop controller MAIN writes for segment/page; the new value is used
    // from the next region write onwards
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_mod_seg  <= 1'b0;
            r_mod_page <= 1'b0;
            r_stm_seg  <= 1'b0;
            r_stm_page <= 4'd0;
        end else if (w_main_wr) begin
            if (r_addr2[7:0] == ADDR_MOD_WR_SEG)  r_mod_seg  <= r_data2[0];
            if (r_addr2[7:0] == ADDR_MOD_WR_PAGE) r_mod_page <= r_data2[0];
            if (r_addr2[7:0] == ADDR_STM_WR_SEG)  r_stm_seg  <= r_data2[0];
            if (r_addr2[7:0] == ADDR_STM_WR_PAGE) r_stm_page <= r_data2[3:0];
        end
    end

    // Output stage: one-cycle region strobe; address and data held until the next write
    always_ff @(posedge BUS_CLK) begin
        if (RST) begin
            r_cnt_we   <= 1'b0;
            r_mod_we   <= 1'b0;
            r_pwe_we   <= 1'b0;
            r_stm_we   <= 1'b0;
            r_cnt_addr <= 14'd0;
            r_mod_addr <= 16'd0;
            r_pwe_addr <= 8'd0;
            r_stm_addr <= 19'd0;
            r_wdata    <= 16'd0;
        end else begin
            r_cnt_we <= r_evt && (r_sel2 == SEL_CONTROLLER);
            r_mod_we <= r_evt && (r_sel2 == SEL_MOD);
            r_pwe_we <= r_evt && (r_sel2 == SEL_PWE_TABLE);
            r_stm_we <= r_evt && (r_sel2 == SEL_STM);
            if (r_evt) begin
                r_wdata <= r_data2;
                if (r_sel2 == SEL_CONTROLLER) r_cnt_addr <= r_addr2;
                if (r_sel2 == SEL_MOD)        r_mod_addr <= {r_mod_seg, r_mod_page, r_addr2};
                if (r_sel2 == SEL_PWE_TABLE)  r_pwe_addr <= r_addr2[7:0];
                if (r_sel2 == SEL_STM)        r_stm_addr <= {r_stm_seg, r_stm_page, r_addr2};
            end
        end
    end

    assign bus.CNT_WE   = r_cnt_we;
    assign bus.MOD_WE   = r_mod_we;
    assign bus.PWE_WE   = r_pwe_we;
    assign bus.STM_WE   = r_stm_we;
    assign bus.CNT_ADDR = r_cnt_addr;
    assign bus.MOD_ADDR = r_mod_addr;
    assign bus.PWE_ADDR = r_pwe_addr;
    assign bus.STM_ADDR = r_stm_addr;
    assign bus.WDATA    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus
// Description : Directed self-checking bench for memory_bus: strobe latency,
//               one pulse per CPU write, region decode, segment/page snooping
//               and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_bus_if bus ();

    memory_bus dut (
        .BUS_CLK (clk),
        .RST     (rst),
        .bus     (bus)
    );

    // Strobe counters, sampled mid-cycle
    int n_cnt = 0;
    int n_mod = 0;
    int n_pwe = 0;
    int n_stm = 0;
    int n_multi = 0;

    always @(negedge clk) begin
        if (bus.CNT_WE === 1'b1) n_cnt++;
        if (bus.MOD_WE === 1'b1) n_mod++;
        if (bus.PWE_WE === 1'b1) n_pwe++;
        if (bus.STM_WE === 1'b1) n_stm++;
        if ((int'(bus.CNT_WE) + int'(bus.MOD_WE) + int'(bus.PWE_WE) + int'(bus.STM_WE)) > 1) n_multi++;
    end

    int checks = 0;
    int errors = 0;
    int b_cnt, b_mod, b_pwe, b_stm;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic we, input logic [1:0] sel,
                         input logic [13:0] addr, input logic [15:0] data);
        bus.EN          = en;
        bus.WE          = we;
        bus.BRAM_SELECT = sel;
        bus.BRAM_ADDR   = addr;
        bus.DATA_IN     = data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One CPU write held for 'hold' sampling edges, then bus released and drained
    task automatic wr(input logic [1:0] sel, input logic [13:0] addr, input logic [15:0] data,
                      input int hold);
        @(negedge clk);
        drive(1'b1, 1'b1, sel, addr, data);
        repeat (hold) @(negedge clk);
        drive(1'b0, 1'b0, sel, addr, data);
        idle(4);
    endtask

    task automatic snap();
        b_cnt = n_cnt;
        b_mod = n_mod;
        b_pwe = n_pwe;
        b_stm = n_stm;
    endtask

    task automatic chk_pulses(input string tag, input int c, input int m, input int p, input int s);
        chk({tag, "_cnt"}, 32'(n_cnt - b_cnt), 32'(c));
        chk({tag, "_mod"}, 32'(n_mod - b_mod), 32'(m));
        chk({tag, "_pwe"}, 32'(n_pwe - b_pwe), 32'(p));
        chk({tag, "_stm"}, 32'(n_stm - b_stm), 32'(s));
    endtask

    initial begin
        drive(1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        rst = 1'b1;
        idle(3);

        // Reset state
        chk("rst_we",   {28'd0, bus.CNT_WE, bus.MOD_WE, bus.PWE_WE, bus.STM_WE}, 32'd0);
        chk("rst_cnta", 32'(bus.CNT_ADDR), 32'd0);
        chk("rst_moda", 32'(bus.MOD_ADDR), 32'd0);
        chk("rst_pwea", 32'(bus.PWE_ADDR), 32'd0);
        chk("rst_stma", 32'(bus.STM_ADDR), 32'd0);
        chk("rst_wdat", 32'(bus.WDATA),    32'd0);
        rst = 1'b0;
        idle(2);

        // PWE write: strobe appears two edges after the sampling edge, one cycle wide
        snap();
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 14'd5, 16'h01FF);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e0", 32'(bus.PWE_WE), 32'd0);
        drive(1'b0, 1'b0, 2'd2, 14'd5, 16'h01FF);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e1", 32'(bus.PWE_WE), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e2", 32'(bus.PWE_WE), 32'd1);
        chk("pwe_addr", 32'(bus.PWE_ADDR), 32'd5);
        chk("pwe_data", 32'(bus.WDATA), 32'h01FF);
        @(negedge clk);
        chk("lat_e3", 32'(bus.PWE_WE), 32'd0);
        idle(2);
        chk_pulses("pwe", 0, 0, 1, 0);

        // Modulation page 1, then top modulation address
        snap();
        wr(2'd0, 14'h0021, 16'h0001, 1);
        wr(2'd1, 14'h3FFF, 16'hA55A, 1);
        chk_pulses("mod", 1, 1, 0, 0);
        chk("mod_addr", 32'(bus.MOD_ADDR), 32'h7FFF);
        chk("mod_data", 32'(bus.WDATA), 32'hA55A);

        // STM segment 1, page F, then STM address 3
        snap();
        wr(2'd0, 14'h0050, 16'h0001, 1);
        wr(2'd0, 14'h0051, 16'h000F, 1);
        wr(2'd3, 14'd3, 16'h1234, 1);
        chk_pulses("stm", 2, 0, 0, 1);
        chk("stm_addr", 32'(bus.STM_ADDR), 32'h7C003);

        // WE held 5 cycles with address/data change mid-hold: one strobe, first address
        snap();
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 14'd9, 16'h1111);
        idle(2);
        drive(1'b1, 1'b1, 2'd2, 14'd10, 16'h2222);
        idle(3);
        drive(1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        idle(4);
        chk_pulses("hold", 0, 0, 1, 0);
        chk("hold_addr", 32'(bus.PWE_ADDR), 32'd9);
        chk("hold_data", 32'(bus.WDATA), 32'h1111);

        // Back-to-back writes with a single idle cycle between them
        snap();
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 14'd20, 16'hAAAA);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd2, 14'd20, 16'hAAAA);
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd2, 14'd21, 16'hBBBB);
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        idle(4);
        chk_pulses("b2b", 0, 0, 2, 0);
        chk("b2b_addr", 32'(bus.PWE_ADDR), 32'd21);

        // Non-MAIN controller writes strobe CNT_WE but leave segment/page alone
        snap();
        wr(2'd0, 14'h0107, 16'hBEEF, 1);
        chk("pc_addr", 32'(bus.CNT_ADDR), 32'h0107);
        chk("pc_data", 32'(bus.WDATA), 32'hBEEF);
        wr(2'd0, 14'h0121, 16'h0000, 1);
        wr(2'd0, 14'h0150, 16'h0000, 1);
        chk_pulses("pc", 3, 0, 0, 0);
        wr(2'd1, 14'd0, 16'h0F0F, 1);
        chk("pc_moda", 32'(bus.MOD_ADDR), 32'h4000);
        wr(2'd3, 14'd3, 16'h0F0F, 1);
        chk("pc_stma", 32'(bus.STM_ADDR), 32'h7C003);

        // EN low or WE low: no strobe
        snap();
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 14'd7, 16'h7777);
        idle(3);
        drive(1'b1, 1'b0, 2'd2, 14'd7, 16'h7777);
        idle(3);
        drive(1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        idle(4);
        chk_pulses("nowr", 0, 0, 0, 0);

        // Reset with a write held across release
        @(negedge clk);
        drive(1'b1, 1'b1, 2'd1, 14'd5, 16'hAAAA);
        idle(2);
        rst = 1'b1;
        idle(2);
        chk("rr_we",   {28'd0, bus.CNT_WE, bus.MOD_WE, bus.PWE_WE, bus.STM_WE}, 32'd0);
        chk("rr_moda", 32'(bus.MOD_ADDR), 32'd0);
        chk("rr_stma", 32'(bus.STM_ADDR), 32'd0);
        chk("rr_wdat", 32'(bus.WDATA), 32'd0);
        snap();
        rst = 1'b0;
        idle(5);
        drive(1'b0, 1'b0, 2'd0, 14'd0, 16'd0);
        idle(3);
        chk_pulses("rhold", 0, 0, 0, 0);
        snap();
        wr(2'd1, 14'd2, 16'h5555, 1);
        chk("rr_mod2", 32'(bus.MOD_ADDR), 32'h0002);
        wr(2'd3, 14'd3, 16'h6666, 1);
        chk("rr_stm3", 32'(bus.STM_ADDR), 32'h00003);
        chk_pulses("rpost", 0, 1, 0, 1);

        chk("onehot", 32'(n_multi), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
